// File: rtl/tile_stat_encoder.sv
// rtl/tile_stat_encoder.sv - serial per-tile point statistics encoder for the pillar feature network
// Walks 8 point slots of an accepted tile, one per cycle, then holds the feature vector until taken.
module tile_stat_encoder #(
    parameter bit SKIP_EMPTY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1023:0] in_tile,
    input  logic [7:0]    in_mask,
    input  logic [7:0]    in_idx,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [175:0]  out_feat,
    output logic [7:0]    out_idx,
    output logic          out_last
);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    localparam logic [31:0] MAX_Z_INIT = 32'h8000_0000;

    state_t               state;
    logic [1023:0]        tile_q;
    logic [7:0]           mask_q;
    logic [7:0]           idx_q;
    logic                 last_q;
    logic [2:0]           slot;
    logic [3:0]           count;
    logic signed [34:0]   sum_x;
    logic signed [34:0]   sum_y;
    logic signed [34:0]   sum_z;
    logic [31:0]          max_z;
    logic [31:0]          max_i;
    logic                 ready_q;
    logic                 valid_q;

    logic [127:0]         cur_pt;
    logic                 cur_hit;
    logic signed [31:0]   pt_x;
    logic signed [31:0]   pt_y;
    logic signed [31:0]   pt_z;
    logic [31:0]          pt_i;
    logic                 accept;
    logic                 skip;

    always_comb begin
        cur_pt  = tile_q[{slot, 7'd0} +: 128];
        cur_hit = mask_q[slot];
        pt_x    = cur_pt[31:0];
        pt_y    = cur_pt[63:32];
        pt_z    = cur_pt[95:64];
        pt_i    = cur_pt[127:96];
    end

    assign accept = in_valid & ready_q;
    // A last tile is never skipped so the frame boundary always reaches downstream.
    assign skip   = SKIP_EMPTY && (in_mask == 8'd0) && !in_last;

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_feat  = {3'b000, count, sum_x, sum_y, sum_z, max_z, max_i};
    assign out_idx   = idx_q;
    assign out_last  = last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tile_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            slot    <= '0;
            count   <= '0;
            sum_x   <= '0;
            sum_y   <= '0;
            sum_z   <= '0;
            max_z   <= '0;
            max_i   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    if (accept && !skip) begin
                        tile_q  <= in_tile;
                        mask_q  <= in_mask;
                        idx_q   <= in_idx;
                        last_q  <= in_last;
                        slot    <= '0;
                        count   <= '0;
                        sum_x   <= '0;
                        sum_y   <= '0;
                        sum_z   <= '0;
                        max_z   <= MAX_Z_INIT;
                        max_i   <= '0;
                        ready_q <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (cur_hit) begin
                        count <= count + 4'd1;
                        sum_x <= sum_x + 35'(pt_x);
                        sum_y <= sum_y + 35'(pt_y);
                        sum_z <= sum_z + 35'(pt_z);
                        if (pt_z > $signed(max_z)) begin
                            max_z <= pt_z;
                        end
                        if (pt_i > max_i) begin
                            max_i <= pt_i;
                        end
                    end
                    slot <= slot + 3'd1;
                    if (slot == 3'd7) begin
                        valid_q <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tile_stat_encoder.md
# tile_stat_encoder

Downstream consumer of the LiDAR point-cloud tiler. It accepts one tile per handshake: 1024 bits holding 8 point slots plus an occupancy mask, tile index and frame-last flag. It walks the 8 slots serially and produces a per-tile statistics vector (point count, coordinate sums, max height, max intensity) for the pillar feature network. Both the input and output sides use valid/ready handshakes.

## Interface
- SKIP_EMPTY, 0, when 1 a tile with in_mask==0 and in_last==0 is consumed without emitting an output
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  tile presented
- in_ready  output  1  block can accept a tile
- in_tile  input  1024  slot k = bits [128k+127:128k]; in each slot x[31:0], y[63:32], z[95:64] are signed, intensity[127:96] is unsigned
- in_mask  input  8  bit k set = slot k holds a valid point
- in_idx  input  8  tile index 0..255
- in_last  input  1  final tile of the frame
- out_valid  output  1  feature vector valid
- out_ready  input  1  downstream accepts
- out_feat  output  176  {3'b0, count[3:0], sum_x[34:0], sum_y[34:0], sum_z[34:0], max_z[31:0], max_i[31:0]}, MSB first
- out_idx  output  8  tile index of out_feat
- out_last  output  1  copy of in_last for this tile

## Operation
- FSM states: IDLE, ACCUM, EMIT.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready: register tile, mask, idx and last; clear the accumulators (count=0, sums=0, max_z=32'h8000_0000, max_i=0); set slot=0; go to ACCUM.
  - Exception: if SKIP_EMPTY=1, in_mask==0 and in_last==0, stay in IDLE and emit nothing.
- ACCUM
  - in_ready=0.
  - Each cycle, if mask[slot]: count+=1; sum_x/y/z += sign-extended x/y/z; max_z = signed max; max_i = unsigned max.
  - slot increments each cycle. After slot 7, go to EMIT.
- EMIT
  - out_valid=1; out_feat, out_idx and out_last are driven from registers.
  - On out_valid&out_ready, go to IDLE.
- Arithmetic
  - Sums are 35-bit signed. 8 × 32-bit cannot overflow, so no saturation is needed.
  - count is in the range 0..8.
- Empty tile (mask 0) emitted: count=0, sums=0, max_z=32'h8000_0000, max_i=0.
- A last tile is always emitted, even when empty and SKIP_EMPTY=1, so that out_last is never lost.
- in_valid while in_ready=0 is ignored. Upstream must hold its data until accepted.

## Timing
- Reset (asynchronous, while reset=0):
  - state=IDLE, out_valid=0, out_feat=0, out_idx=0, out_last=0, accumulators and slot cleared.
  - in_ready is forced to 0 while reset=0.
- Deasserting reset makes in_ready=1 on the first clk edge after release.
- Latency: handshake at cycle T; ACCUM spans cycles T+1..T+8; out_valid rises at T+9.
- With out_ready held at 1, in_ready returns at T+10. Maximum throughput is 1 tile per 10 cycles.
- A skipped empty tile occupies only its accept cycle; in_ready stays 1 on the next cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_feat, out_idx and out_last stay stable and in_ready stays 0.
- Reset during ACCUM or EMIT aborts the tile immediately. No partial output appears after reset is released.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from out_ready to in_ready.

## Test plan
- Full tile, all slots (x,y,z,i) = (1,2,3,4), mask 8'hFF, idx 5:
  - out_valid at T+9 with count=8, sum_x=8, sum_y=16, sum_z=24, max_z=3, max_i=4, out_idx=5.
- Sign and extremes: mask 8'h81; slot0 = (-2^31, -1, -5, 0); slot7 = (-2^31, 1, -7, 32'hFFFF_FFFF):
  - count=2, sum_x=-2^32 (35-bit), sum_y=0, sum_z=-12, max_z=-5, max_i=32'hFFFF_FFFF.
- SKIP_EMPTY=1, stream idx 0 (mask 0), idx 1 (mask 8'h01), idx 2 (mask 0, in_last=1):
  - Exactly two outputs: idx 1 with count=1, then idx 2 with count=0, max_z=32'h8000_0000, out_last=1.
  - in_ready=1 on the cycle after idx 0 is accepted.
- Backpressure: hold out_ready=0 for 20 cycles in EMIT:
  - out_feat stable, in_ready=0, in_valid ignored.
  - Release: handshake, then in_ready=1 on the next cycle.
- Reset asserted at ACCUM slot 4:
  - Outputs go to 0 asynchronously, with no output for the aborted tile.
  - The next tile after release is processed correctly.
- SKIP_EMPTY=0, mask 0, idx 9:
  - Emitted at T+9 with count=0, sums 0, max_i=0.
